// File: rtl/router_pkg.sv
// Shared constants for the 1x3 router: byte width, output FIFO depth and header field layout.
// Used by router_fifo, router_sync and router_fsm.
package router_pkg;

    localparam int ROUTER_WIDTH      = 8;
    localparam int ROUTER_FIFO_DEPTH = 16;
    localparam int FIFO_AW           = $clog2(ROUTER_FIFO_DEPTH);

    localparam int HDR_ADDR_LSB = 0;
    localparam int HDR_ADDR_MSB = 1;
    localparam int HDR_LEN_LSB  = 2;
    localparam int HDR_LEN_MSB  = 7;

    localparam int CNT_W = 7;

    // Bytes still to leave after the header: payload length plus the parity byte.
    function automatic logic [CNT_W-1:0] hdr_word_count(input logic [ROUTER_WIDTH-1:0] hdr);
        return {1'b0, hdr[HDR_LEN_MSB:HDR_LEN_LSB]} + 7'd1;
    endfunction

endpackage

// File: rtl/router_fifo_if.sv
// Byte/strobe/flag bundle between router_sync (master) and one output FIFO (slave).
interface router_fifo_if
    import router_pkg::*;
#(
    parameter int WIDTH = ROUTER_WIDTH
);
    logic             write_enb;
    logic             read_enb;
    logic             lfd_state;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             full;
    logic             empty;

    modport master (
        output write_enb, read_enb, lfd_state, data_in,
        input  data_out, full, empty
    );

    modport slave (
        input  write_enb, read_enb, lfd_state, data_in,
        output data_out, full, empty
    );
endinterface

// File: rtl/router_fifo_mem.sv
// Simple dual-port storage for router_fifo: synchronous write, read word presented to the
// owner's data_out register. Contents are deliberately not reset.
module router_fifo_mem
    import router_pkg::*;
#(
    parameter int DEPTH = ROUTER_FIFO_DEPTH,
    parameter int W     = ROUTER_WIDTH + 1
) (
    input  logic                     clock,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [W-1:0]             wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [W-1:0]             rd_data
);
    logic [W-1:0] mem_r [DEPTH];

    // Storage write port.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/router_fifo.sv
// One router output FIFO: tagged storage, wrap-flag pointers, packet byte counter and idle output.
// Build option ROUTER_FIFO_TRISTATE_EN: idle data_out floats ('z) instead of being driven 0.
module router_fifo
    import router_pkg::*;
#(
    parameter int DEPTH = ROUTER_FIFO_DEPTH,
    parameter int WIDTH = ROUTER_WIDTH
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         soft_reset,
    router_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_next_s;
    logic [WIDTH-1:0] data_r;
    logic [WIDTH:0]   rd_word_s;
    logic             full_s;
    logic             empty_s;
    logic             wr_acc_s;
    logic             rd_acc_s;
    logic             idle_s;

    // Flags come only from the pointer registers, never from the strobes.
    assign empty_s  = (wr_ptr_r == rd_ptr_r);
    assign full_s   = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);
    assign wr_acc_s = bus.write_enb & ~full_s;
    assign rd_acc_s = bus.read_enb & ~empty_s;
    assign idle_s   = ~rd_acc_s && (count_r == {CNT_W{1'b0}});

    router_fifo_mem #(
        .DEPTH (DEPTH),
        .W     (WIDTH + 1)
    ) u_mem (
        .clock   (clock),
        .wr_en   (wr_acc_s & ~soft_reset),
        .wr_addr (wr_ptr_r[AW-1:0]),
        .wr_data ({bus.lfd_state, bus.data_in}),
        .rd_addr (rd_ptr_r[AW-1:0]),
        .rd_data (rd_word_s)
    );

    // Write and read pointers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else if (soft_reset) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            wr_ptr_r <= wr_acc_s ? wr_ptr_r + {{AW{1'b0}}, 1'b1} : wr_ptr_r;
            rd_ptr_r <= rd_acc_s ? rd_ptr_r + {{AW{1'b0}}, 1'b1} : rd_ptr_r;
        end
    end

    // Packet byte counter: a tagged word (re)loads, untagged reads count down to zero.
    always_comb begin
        count_next_s = count_r;
        if (rd_acc_s) begin
            if (rd_word_s[WIDTH]) begin
                count_next_s = hdr_word_count(rd_word_s[ROUTER_WIDTH-1:0]);
            end else if (count_r != {CNT_W{1'b0}}) begin
                count_next_s = count_r - 7'd1;
            end else begin
                count_next_s = count_r;
            end
        end else begin
            count_next_s = count_r;
        end
    end

    // Counter and output data registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count_r <= {CNT_W{1'b0}};
            data_r  <= {WIDTH{1'b0}};
        end else if (soft_reset) begin
            count_r <= {CNT_W{1'b0}};
            data_r  <= {WIDTH{1'b0}};
        end else begin
            count_r <= count_next_s;
            if (rd_acc_s) begin
                data_r <= rd_word_s[WIDTH-1:0];
            end else if (idle_s) begin
                data_r <= {WIDTH{1'b0}};
            end else begin
                data_r <= data_r;
            end
        end
    end

`ifdef ROUTER_FIFO_TRISTATE_EN
    logic oe_r;

    // Output enable: on after an accepted read, off whenever the output goes idle.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            oe_r <= 1'b0;
        end else if (soft_reset) begin
            oe_r <= 1'b0;
        end else if (rd_acc_s) begin
            oe_r <= 1'b1;
        end else if (idle_s) begin
            oe_r <= 1'b0;
        end else begin
            oe_r <= oe_r;
        end
    end

    assign bus.data_out = oe_r ? data_r : {WIDTH{1'bz}};
`else
    assign bus.data_out = data_r;
`endif

    assign bus.full  = full_s;
    assign bus.empty = empty_s;

endmodule

// File: tb/tb_router_fifo.sv
// Self-checking bench for router_fifo: directed scenarios plus random traffic against a
// queue-based reference model of the FIFO, packet counter and idle output.
module tb_router_fifo;
    import router_pkg::*;

    localparam int W = ROUTER_WIDTH;
    localparam int D = ROUTER_FIFO_DEPTH;

    logic clock      = 1'b0;
    logic resetn     = 1'b0;
    logic soft_reset = 1'b0;

    router_fifo_if #(.WIDTH(W)) bus ();

    router_fifo #(.DEPTH(D), .WIDTH(W)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .soft_reset (soft_reset),
        .bus        (bus.slave)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [W:0]   mq[$];
    int           m_count;
    logic [W-1:0] m_dout;
    bit           m_oe;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        m_count = 0;
        m_dout  = '0;
        m_oe    = 1'b0;
    endfunction

    function automatic void model_edge(bit w, bit r, bit lfd, logic [W-1:0] d, bit s);
        bit         was_full;
        bit         was_empty;
        logic [W:0] word;
        was_full  = (mq.size() == D);
        was_empty = (mq.size() == 0);
        if (s) begin
            model_reset();
            return;
        end
        if (r && !was_empty) begin
            word   = mq.pop_front();
            m_dout = word[W-1:0];
            m_oe   = 1'b1;
            if (word[W]) m_count = int'(word[W-1:2]) + 1;
            else if (m_count > 0) m_count--;
        end else if (m_count == 0) begin
            m_dout = '0;
            m_oe   = 1'b0;
        end
        if (w && !was_full) mq.push_back({lfd, d});
    endfunction

    task automatic compare();
        logic [W-1:0] exp_d;
        exp_d = m_dout;
`ifdef ROUTER_FIFO_TRISTATE_EN
        if (!m_oe) exp_d = {W{1'bz}};
`endif
        chk("data_out", {8'h00, bus.data_out}, {8'h00, exp_d});
        chk("full",  {15'h0, bus.full},  {15'h0, mq.size() == D});
        chk("empty", {15'h0, bus.empty}, {15'h0, mq.size() == 0});
    endtask

    task automatic cyc(input bit w, input bit r, input bit lfd, input logic [W-1:0] d, input bit s);
        bus.write_enb = w;
        bus.read_enb  = r;
        bus.lfd_state = lfd;
        bus.data_in   = d;
        soft_reset    = s;
        @(posedge clock);
        model_edge(w, r, lfd, d, s);
        #1;
        compare();
    endtask

    initial begin
        bus.write_enb = 1'b0;
        bus.read_enb  = 1'b0;
        bus.lfd_state = 1'b0;
        bus.data_in   = '0;
        model_reset();

        // Reset then idle.
        repeat (2) @(posedge clock);
        #1;
        compare();
        resetn = 1'b1;
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

        // Single packet: header len 3, payload, parity, then six read strobes.
        cyc(1'b1, 1'b0, 1'b1, 8'h0D, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 8'hA1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 8'hA2, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 8'hA3, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 8'h5F, 1'b0);
        repeat (6) cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

        // Full boundary, dropped write, simultaneous strobes when full, drain.
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 1'b0, 8'($urandom_range(0, 254)), 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 8'hFF, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 8'hFF, 1'b0);
        repeat (15) cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

        // Simultaneous strobes when empty: write only.
        cyc(1'b1, 1'b1, 1'b0, 8'h3C, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

        // Wrap-around: interleaved write/read pairs.
        for (int i = 0; i < 40; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 8'(i), 1'b0);
            cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        end

        // Soft reset mid-packet, then a fresh packet.
        cyc(1'b1, 1'b0, 1'b1, 8'h0C, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 8'h11, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 8'h22, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 8'h33, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 8'h44, 1'b0);
        repeat (3) cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 8'h99, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 8'h05, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 8'h6A, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 8'h6B, 1'b0);
        repeat (4) cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

        // Random traffic with occasional headers and soft resets.
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 7) == 0, 8'($urandom), $urandom_range(0, 63) == 0);
        end

        // Asynchronous reset mid-packet aborts immediately.
        cyc(1'b1, 1'b0, 1'b1, 8'h08, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 8'h77, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        bus.read_enb = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        compare();
        #3;
        resetn = 1'b1;
        repeat (2) cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
